// File: rtl/blast_pkg.sv
// Shared constants and width helpers for the BLAST-style seed/extension datapath.
package blast_pkg;

  localparam logic [1:0] BASE_A = 2'b00;
  localparam logic [1:0] BASE_C = 2'b01;
  localparam logic [1:0] BASE_G = 2'b10;
  localparam logic [1:0] BASE_T = 2'b11;

  localparam int DEFAULT_MATCH     = 5;
  localparam int DEFAULT_MISMATCH  = 4;
  localparam int DEFAULT_THRESHOLD = 20;

  // Signed width able to hold n*match, plus a sign bit.
  function automatic int score_w(input int n, input int match);
    return $clog2(n * match + 1) + 1;
  endfunction

endpackage

// File: rtl/prefix_max_scorer.sv
// Combinational scorer: match bitmap -> clamped full-word score, best prefix score and its length.
module prefix_max_scorer
  import blast_pkg::*;
#(
  parameter int NUM_BASES = 11,
  parameter int MATCH     = DEFAULT_MATCH,
  parameter int MISMATCH  = DEFAULT_MISMATCH,
  localparam int SCORE_W  = score_w(NUM_BASES, MATCH),
  localparam int LEN_W    = $clog2(NUM_BASES + 1)
) (
  input  logic [NUM_BASES-1:0] match_map_i,
  output logic [SCORE_W-2:0]   score_o,
  output logic [SCORE_W-2:0]   best_o,
  output logic [LEN_W-1:0]     best_len_o
);

  // Accumulator also wide enough for the most negative running sum.
  localparam int NEG_W = score_w(NUM_BASES, MISMATCH);
  localparam int ACC_W = (NEG_W > SCORE_W) ? NEG_W : SCORE_W;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] top;

  always_comb begin
    acc        = '0;
    top        = '0;
    best_len_o = '0;
    for (int k = 0; k < NUM_BASES; k++) begin
      if (match_map_i[k]) begin
        acc = acc + ACC_W'(MATCH);
      end else begin
        acc = acc - ACC_W'(MISMATCH);
      end
      // Strict compare keeps the shortest prefix on ties and leaves 0/0 when nothing is positive.
      if (acc > top) begin
        top        = acc;
        best_len_o = LEN_W'(k + 1);
      end
    end
    score_o = (acc > 0) ? acc[SCORE_W-2:0] : '0;
    best_o  = top[SCORE_W-2:0];
  end

endmodule

// File: rtl/seed_ungapped_scorer.sv
// Two-stage valid/ready pipeline scoring a query word against a DB word with a saturating hit counter.
module seed_ungapped_scorer
  import blast_pkg::*;
#(
  parameter int NUM_BASES = 11,
  parameter int MATCH     = DEFAULT_MATCH,
  parameter int MISMATCH  = DEFAULT_MISMATCH,
  parameter int THRESHOLD = DEFAULT_THRESHOLD,
  parameter int TAG_W     = 32,
  parameter int CNT_W     = 16,
  localparam int SCORE_W  = score_w(NUM_BASES, MATCH),
  localparam int LEN_W    = $clog2(NUM_BASES + 1),
  localparam int WORD_W   = 2 * NUM_BASES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_W-1:0]    in_query,
  input  logic [WORD_W-1:0]    in_db,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SCORE_W-2:0]   out_score,
  output logic [SCORE_W-2:0]   out_best,
  output logic [LEN_W-1:0]     out_best_len,
  output logic                 out_hit,
  output logic [TAG_W-1:0]     out_tag,
  output logic [CNT_W-1:0]     hit_count,
  input  logic                 clear_count
);

  if (NUM_BASES < 1) begin : g_bad_num_bases
    $error("seed_ungapped_scorer: NUM_BASES must be >= 1");
  end
  if (MATCH <= 0) begin : g_bad_match
    $error("seed_ungapped_scorer: MATCH must be > 0");
  end
  if (MISMATCH <= 0) begin : g_bad_mismatch
    $error("seed_ungapped_scorer: MISMATCH must be > 0");
  end

  logic                 s1_valid_q, s1_valid_d;
  logic [NUM_BASES-1:0] s1_match_q, s1_match_d;
  logic [TAG_W-1:0]     s1_tag_q, s1_tag_d;

  logic                 s2_valid_q, s2_valid_d;
  logic [SCORE_W-2:0]   s2_score_q, s2_score_d;
  logic [SCORE_W-2:0]   s2_best_q, s2_best_d;
  logic [LEN_W-1:0]     s2_len_q, s2_len_d;
  logic                 s2_hit_q, s2_hit_d;
  logic [TAG_W-1:0]     s2_tag_q, s2_tag_d;

  logic [CNT_W-1:0]     hit_count_q, hit_count_d;

  logic                 s2_adv, s1_adv, in_fire, hit_fire;
  logic [NUM_BASES-1:0] match_map;
  logic [SCORE_W-2:0]   scr_score, scr_best;
  logic [LEN_W-1:0]     scr_len;

  prefix_max_scorer #(
    .NUM_BASES (NUM_BASES),
    .MATCH     (MATCH),
    .MISMATCH  (MISMATCH)
  ) u_scorer (
    .match_map_i (s1_match_q),
    .score_o     (scr_score),
    .best_o      (scr_best),
    .best_len_o  (scr_len)
  );

  // Bit i of the map is base i; base 0 sits in the most significant pair.
  always_comb begin
    match_map = '0;
    for (int i = 0; i < NUM_BASES; i++) begin
      match_map[i] = (in_query[2*(NUM_BASES-1-i) +: 2] == in_db[2*(NUM_BASES-1-i) +: 2]);
    end
  end

  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = s1_valid_q && s2_adv;
    in_ready = !s1_valid_q || s1_adv;
    in_fire  = in_valid && in_ready;
    hit_fire = s2_valid_q && out_ready && s2_hit_q;

    s1_valid_d = in_fire || (s1_valid_q && !s1_adv);
    s1_match_d = in_fire ? match_map : s1_match_q;
    s1_tag_d   = in_fire ? in_tag : s1_tag_q;

    s2_valid_d = s1_adv || (s2_valid_q && !out_ready);
    s2_score_d = s2_score_q;
    s2_best_d  = s2_best_q;
    s2_len_d   = s2_len_q;
    s2_hit_d   = s2_hit_q;
    s2_tag_d   = s2_tag_q;
    if (s1_adv) begin
      s2_score_d = scr_score;
      s2_best_d  = scr_best;
      s2_len_d   = scr_len;
      s2_hit_d   = (int'(scr_best) >= THRESHOLD);
      s2_tag_d   = s1_tag_q;
    end

    hit_count_d = hit_count_q;
    if (clear_count) begin
      hit_count_d = hit_fire ? CNT_W'(1) : '0;
    end else if (hit_fire && (hit_count_q != '1)) begin
      hit_count_d = hit_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_match_q  <= '0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_score_q  <= '0;
      s2_best_q   <= '0;
      s2_len_q    <= '0;
      s2_hit_q    <= 1'b0;
      s2_tag_q    <= '0;
      hit_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_match_q  <= s1_match_d;
      s1_tag_q    <= s1_tag_d;
      s2_valid_q  <= s2_valid_d;
      s2_score_q  <= s2_score_d;
      s2_best_q   <= s2_best_d;
      s2_len_q    <= s2_len_d;
      s2_hit_q    <= s2_hit_d;
      s2_tag_q    <= s2_tag_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_score    = s2_score_q;
  assign out_best     = s2_best_q;
  assign out_best_len = s2_len_q;
  assign out_hit      = s2_hit_q;
  assign out_tag      = s2_tag_q;
  assign hit_count    = hit_count_q;

endmodule

// File: tb/tb_seed_ungapped_scorer.sv
// Directed bench for seed_ungapped_scorer (11 bases, 5/4 scoring, threshold 20, 2-bit hit counter).
module tb_seed_ungapped_scorer;

  localparam int CNT_MAX = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [21:0] in_query;
  logic [21:0] in_db;
  logic [31:0] in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_score;
  logic [5:0]  out_best;
  logic [3:0]  out_best_len;
  logic        out_hit;
  logic [31:0] out_tag;
  logic [1:0]  hit_count;
  logic        clear_count;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;
  int exp_c[7] = '{0, 0, 1, 2, 3, 3, 3};

  seed_ungapped_scorer #(
    .CNT_W (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_query     (in_query),
    .in_db        (in_db),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_score    (out_score),
    .out_best     (out_best),
    .out_best_len (out_best_len),
    .out_hit      (out_hit),
    .out_tag      (out_tag),
    .hit_count    (hit_count),
    .clear_count  (clear_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated word with out_ready high: checks 2-cycle latency, result fields and hit counting.
  task automatic run_one(input string name, input logic [21:0] q, input logic [21:0] db,
                         input logic [31:0] tag, input int e_score, input int e_best,
                         input int e_len, input int e_hit);
    check_eq({name, ".in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    in_query = q;
    in_db    = db;
    in_tag   = tag;
    tick();
    in_valid = 1'b0;
    check_eq({name, ".lat1_valid"}, out_valid, 0);
    tick();
    check_eq({name, ".valid"}, out_valid, 1);
    check_eq({name, ".score"}, out_score, e_score);
    check_eq({name, ".best"}, out_best, e_best);
    check_eq({name, ".best_len"}, out_best_len, e_len);
    check_eq({name, ".hit"}, out_hit, e_hit);
    check_eq({name, ".tag"}, out_tag, tag);
    tick();
    if (e_hit != 0 && exp_cnt < CNT_MAX) exp_cnt++;
    check_eq({name, ".drained"}, out_valid, 0);
    check_eq({name, ".hit_count"}, hit_count, exp_cnt);
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_query    = '0;
    in_db       = '0;
    in_tag      = '0;
    out_ready   = 1'b1;
    clear_count = 1'b0;
    #12;
    check_eq("rst.out_valid", out_valid, 0);
    check_eq("rst.in_ready", in_ready, 1);
    check_eq("rst.hit_count", hit_count, 0);
    check_eq("rst.out_best", out_best, 0);
    check_eq("rst.out_tag", out_tag, 0);
    tick();
    rst = 1'b0;
    tick();

    run_one("identical", 22'h2A5F13, 22'h2A5F13, 32'hA1, 55, 55, 11, 1);
    run_one("all_mis", 22'h000000, 22'h3FFFFF, 32'hA2, 0, 0, 0, 0);
    run_one("m5_x6", 22'h000000, 22'h000FFF, 32'hA3, 1, 25, 5, 1);
    run_one("tie_first", 22'h000000, 22'h0FFC03, 32'hA4, 1, 5, 1, 0);
    run_one("low_bit_diff", 22'h155555, 22'h000000, 32'hA5, 0, 0, 0, 0);
    run_one("thr_eq", 22'h000000, 22'h003FFF, 32'hA6, 0, 20, 4, 1);
    run_one("thr_below", 22'h000000, 22'h3FC000, 32'hA7, 19, 19, 11, 0);

    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    exp_cnt = 0;
    check_eq("clear.hit_count", hit_count, 0);

    // Backpressure: two words fill the pipe, third waits.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_query  = 22'h000000;
    in_db     = 22'h000000;
    in_tag    = 32'd1;
    check_eq("bp.ready0", in_ready, 1);
    tick();
    in_tag = 32'd2;
    check_eq("bp.ready1", in_ready, 1);
    tick();
    in_tag = 32'd3;
    check_eq("bp.ready2", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      check_eq("bp.hold_valid", out_valid, 1);
      check_eq("bp.hold_tag", out_tag, 1);
      check_eq("bp.hold_ready", in_ready, 0);
      check_eq("bp.hold_cnt", hit_count, 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp.ready_release", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check_eq("bp.tag2", out_tag, 2);
    check_eq("bp.cnt1", hit_count, 1);
    tick();
    check_eq("bp.tag3", out_tag, 3);
    check_eq("bp.valid3", out_valid, 1);
    check_eq("bp.cnt2", hit_count, 2);
    tick();
    check_eq("bp.empty", out_valid, 0);
    check_eq("bp.cnt3", hit_count, 3);

    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;

    // Five back-to-back hits into a 2-bit counter.
    for (int i = 0; i < 7; i++) begin
      in_valid = (i < 5);
      in_tag   = 32'(10 + i);
      tick();
      check_eq("sat.hit_count", hit_count, exp_c[i]);
      check_eq("sat.valid", out_valid, (i >= 1 && i <= 5) ? 1 : 0);
      if (i >= 1 && i <= 5) check_eq("sat.tag", out_tag, 9 + i);
    end
    in_valid = 1'b0;

    // Clear coinciding with a counted hit.
    in_valid = 1'b1;
    in_tag   = 32'd20;
    tick();
    in_valid = 1'b0;
    tick();
    check_eq("clr_hit.valid", out_valid, 1);
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    check_eq("clr_hit.hit_count", hit_count, 1);
    exp_cnt = 1;

    // Reset with both stages occupied.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_tag    = 32'd30;
    tick();
    in_tag = 32'd31;
    tick();
    in_valid = 1'b0;
    check_eq("mid.full_valid", out_valid, 1);
    check_eq("mid.full_ready", in_ready, 0);
    rst = 1'b1;
    #1;
    check_eq("mid.rst_valid", out_valid, 0);
    check_eq("mid.rst_ready", in_ready, 1);
    check_eq("mid.rst_cnt", hit_count, 0);
    exp_cnt = 0;
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    tick();
    check_eq("mid.no_leftover", out_valid, 0);
    run_one("after_rst", 22'h000000, 22'h000FFF, 32'hB1, 1, 25, 5, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seed_ungapped_scorer.md
Name: seed_ungapped_scorer

Overview:
- Parametrised successor to the fixed 11-base seed comparator. Scores a query word against a database word, base by base: +MATCH per equal 2-bit base, -MISMATCH per unequal base.
- Also computes the best ungapped prefix extension and its length, flags hits against a threshold, carries a position tag, and keeps a saturating hit counter.
- Two-stage pipeline with valid/ready on both sides; sits between the DB word streamer and the hit/extension collector.

Parameters:
- NUM_BASES, 11, bases per word; word width is 2*NUM_BASES.
- MATCH, 5, reward per matching base (positive).
- MISMATCH, 4, penalty magnitude per mismatching base (positive; subtracted).
- THRESHOLD, 20, hit when best_score >= THRESHOLD.
- TAG_W, 32, width of the pass-through position tag.
- CNT_W, 16, hit counter width.
- Derived SCORE_W = $clog2(NUM_BASES*MATCH+1)+1 (signed internal width); LEN_W = $clog2(NUM_BASES+1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept
- in_query  in  2*NUM_BASES  query word; base 0 = MSB pair
- in_db  in  2*NUM_BASES  database word; same ordering
- in_tag  in  TAG_W  DB position tag
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_score  out  SCORE_W-1  full-word score clamped at 0 (unsigned)
- out_best  out  SCORE_W-1  best prefix score clamped at 0
- out_best_len  out  LEN_W  bases in best prefix (0 if none positive)
- out_hit  out  1  out_best >= THRESHOLD
- out_tag  out  TAG_W  tag of this result
- hit_count  out  CNT_W  accepted hits since reset/clear, saturating
- clear_count  in  1  synchronous counter clear

Behaviour:
- Reset (async assert, sync-safe deassert): all stage valids 0, out_valid 0, in_ready 1, hit_count 0, all data registers 0.
- Stage 1 registers: per-base match bitmap (bit i = query base i == db base i) and tag.
- Stage 2 registers:
  - raw = sum over bases of +MATCH/-MISMATCH, signed SCORE_W, no overflow by construction.
  - Prefix sums P(k), k=1..NUM_BASES, walked from base 0.
  - best = max P(k); best_len = smallest k achieving the max.
  - If max <= 0: best = 0, best_len = 0.
  - out_score = raw <= 0 ? 0 : raw.
- Latency: accepted input appears on outputs exactly 2 cycles later when out_ready is held high. Throughput 1 word/cycle.
- Handshake:
  - A stage advances when its successor is empty or is being consumed this cycle.
  - in_ready = !s1_valid || s1 advances.
  - Outputs hold stable while out_valid && !out_ready.
  - No bubbles are inserted and no data is dropped or duplicated.
  - Order is preserved.
- Capacity: 2 words in flight; with out_ready low, in_ready falls after 2 accepted words.
- Hit counter:
  - Increments on out_valid && out_ready && out_hit.
  - Saturates at 2^CNT_W-1.
  - clear_count takes priority; clear and a counted hit in the same cycle give hit_count = 1.
- Reset mid-operation: in-flight words are discarded with no output handshake.
- Illegal parameters (MATCH or MISMATCH <= 0, NUM_BASES < 1) are rejected by elaboration-time assertion.

Decomposition:
- Shared blast_pkg holds:
  - base encoding constants (A=2'b00, C=2'b01, G=2'b10, T=2'b11);
  - default MATCH/MISMATCH/THRESHOLD;
  - score_w(n, match) width function.
- One sub-module, prefix_max_scorer: combinational, maps bitmap to raw/best/best_len. It is instantiated in stage 2 and reusable by the future gapped extender.

Test Plan:
- Identical query/db (NUM_BASES=11) -> 2 cycles later out_score=55, out_best=55, out_best_len=11, out_hit=1, hit_count=1.
- query=22'h000000, db=22'h3FFFFF (all mismatch) -> out_score=0, out_best=0, out_best_len=0, out_hit=0.
- query=22'h000000, db=22'h000FFF (5 match then 6 mismatch) -> raw 1, out_score=1, out_best=25, out_best_len=5, out_hit=1.
- out_ready low, in_valid high for 3 words (tags 1,2,3) -> in_ready low after 2 acceptances, outputs frozen. Raise out_ready -> tags 1,2,3 delivered in order, one per cycle.
- CNT_W=2 with 5 back-to-back hits -> hit_count 1,2,3,3,3. Then clear_count with a simultaneous hit -> 1.
- Assert rst with 2 words in flight -> out_valid drops immediately, hit_count=0, in_ready=1. After release, the next word produces its result in 2 cycles.
